// File: rtl/am_spi_cfg_master.sv
// SPI mode-0 transmit-only master that frames one WORD_BITS word per CSb low period.
// SCK, MOSI and CSb come straight from flops; every non-idle phase lasts CLK_DIV clocks.
module am_spi_cfg_master #(
    parameter int WORD_BITS = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 SCK,
    output logic                 MOSI,
    output logic                 CSb
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } state_t;

    state_t                 state_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [BIT_W-1:0]       bit_reg;
    logic [WORD_BITS-1:0]   shift_reg;
    logic [WORD_BITS-1:0]   shift_next;
    logic                   sck_reg;
    logic                   mosi_reg;
    logic                   csb_reg;
    logic                   done_reg;
    logic                   ready_reg;
    logic                   busy_reg;
    logic                   accept;
    logic                   div_last;

    assign accept     = tx_valid && ready_reg;
    assign div_last   = (div_reg == DIV_W'(CLK_DIV - 1));
    assign shift_next = shift_reg << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            csb_reg   <= 1'b1;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            // Ready trails the return to IDLE by one clock, so it also rises the cycle after reset.
            ready_reg <= (state_reg == IDLE) && !accept;
            busy_reg  <= accept || (state_reg != IDLE);
            if (state_reg == IDLE) begin
                div_reg <= '0;
                if (accept) begin
                    shift_reg <= tx_data;
                    mosi_reg  <= tx_data[WORD_BITS-1];
                    csb_reg   <= 1'b0;
                    bit_reg   <= BIT_W'(WORD_BITS - 1);
                    state_reg <= SETUP;
                end
            end else if (!div_last) begin
                div_reg <= div_reg + DIV_W'(1);
            end else begin
                div_reg <= '0;
                case (state_reg)
                    SETUP: begin
                        sck_reg   <= 1'b1;
                        state_reg <= SCK_HI;
                    end
                    SCK_HI: begin
                        sck_reg <= 1'b0;
                        if (bit_reg == '0) begin
                            state_reg <= HOLD;
                        end else begin
                            // Falling edge: the next bit goes out half a period before the slave samples it.
                            bit_reg   <= bit_reg - BIT_W'(1);
                            shift_reg <= shift_next;
                            mosi_reg  <= shift_next[WORD_BITS-1];
                            state_reg <= SCK_LO;
                        end
                    end
                    SCK_LO: begin
                        sck_reg   <= 1'b1;
                        state_reg <= SCK_HI;
                    end
                    HOLD: begin
                        csb_reg   <= 1'b1;
                        mosi_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= GAP;
                    end
                    GAP: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready = ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign SCK      = sck_reg;
    assign MOSI     = mosi_reg;
    assign CSb      = csb_reg;

endmodule

// File: tb/tb_am_spi_cfg_master.sv
// Directed bench: two masters (8-bit/div-2 and 32-bit/div-1) observed by a simple mode-0 slave model.
module tb_am_spi_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instance a: 8-bit words, CLK_DIV=2
    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_busy, a_done, a_sck, a_mosi, a_csb;

    am_spi_cfg_master #(.WORD_BITS(8), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .busy(a_busy), .done(a_done),
        .SCK(a_sck), .MOSI(a_mosi), .CSb(a_csb)
    );

    // Instance b: 32-bit words, CLK_DIV=1
    logic [31:0] b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_busy, b_done, b_sck, b_mosi, b_csb;

    am_spi_cfg_master #(.WORD_BITS(32), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .busy(b_busy), .done(b_done),
        .SCK(b_sck), .MOSI(b_mosi), .CSb(b_csb)
    );

    // Slave model for a: shift MOSI in on SCK rises while CSb is low
    int          a_rises = 0, a_len = 0, a_fall_cyc = 0, a_rise_cyc = 0, a_done_cnt = 0, a_done_cyc = 0;
    logic [31:0] a_cap = '0;
    logic        a_sck_p = 1'b0, a_csb_p = 1'b1;
    int          a_acc[$];
    logic [31:0] a_fw[$];
    int          a_fr[$];
    int          a_fl[$];

    always @(negedge clk) begin
        if (a_valid && a_ready && !rst) a_acc.push_back(cyc);
        if (!a_csb) begin
            if (a_csb_p) begin
                a_fall_cyc = cyc; a_rises = 0; a_len = 0; a_cap = '0;
            end
            a_len++;
            if (a_sck && !a_sck_p) begin
                a_cap = {a_cap[30:0], a_mosi};
                a_rises++;
            end
        end else if (!a_csb_p) begin
            a_rise_cyc = cyc;
            a_fw.push_back(a_cap); a_fr.push_back(a_rises); a_fl.push_back(a_len);
        end
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        a_sck_p = a_sck; a_csb_p = a_csb;
    end

    // Slave model for b, with SCK period measurement
    int          b_rises = 0, b_len = 0, b_last_rise = 0, b_per_bad = 0, b_done_cnt = 0;
    logic [31:0] b_cap = '0;
    logic        b_sck_p = 1'b0, b_csb_p = 1'b1;
    int          b_acc[$];
    logic [31:0] b_fw[$];
    int          b_fr[$];
    int          b_fl[$];

    always @(negedge clk) begin
        if (b_valid && b_ready && !rst) b_acc.push_back(cyc);
        if (!b_csb) begin
            if (b_csb_p) begin
                b_rises = 0; b_len = 0; b_cap = '0;
            end
            b_len++;
            if (b_sck && !b_sck_p) begin
                if (b_rises > 0 && (cyc - b_last_rise) != 2) b_per_bad++;
                b_last_rise = cyc;
                b_cap = {b_cap[30:0], b_mosi};
                b_rises++;
            end
        end else if (!b_csb_p) begin
            b_fw.push_back(b_cap); b_fr.push_back(b_rises); b_fl.push_back(b_len);
        end
        if (b_done) b_done_cnt++;
        b_sck_p = b_sck; b_csb_p = b_csb;
    end

    // Raise valid, wait for the accept, drop valid; returns T0 and busy/ready seen at T0+1
    task automatic send_a(input logic [7:0] d, output int t0, output logic bsy, output logic rdy);
        int n;
        n = a_acc.size();
        t0 = -1;
        @(posedge clk); #1;
        a_data = d; a_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (a_acc.size() > n) break;
        end
        check_val("a_accept_timeout", 64'(a_acc.size() > n), 64'd1);
        if (a_acc.size() > n) t0 = a_acc[n];
        @(posedge clk); #1;
        a_valid = 1'b0;
        bsy = a_busy; rdy = a_ready;
        $display("xfer a data=%02h t0=%0d", d, t0);
    endtask

    task automatic wait_ready_a(output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (a_ready) begin c = cyc; break; end
        end
        check_val("a_ready_timeout", 64'(c >= 0), 64'd1);
    endtask

    task automatic send_b(input logic [31:0] d, output int t0);
        int n;
        n = b_acc.size();
        t0 = -1;
        @(posedge clk); #1;
        b_data = d; b_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (b_acc.size() > n) break;
        end
        check_val("b_accept_timeout", 64'(b_acc.size() > n), 64'd1);
        if (b_acc.size() > n) t0 = b_acc[n];
        @(posedge clk); #1;
        b_valid = 1'b0;
        $display("xfer b data=%08h t0=%0d", d, t0);
    endtask

    task automatic wait_ready_b(output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (b_ready) begin c = cyc; break; end
        end
        check_val("b_ready_timeout", 64'(c >= 0), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, t1, rc, d0, nf, na, bad;
        logic bsy, rdy;

        // Asynchronous reset: outputs must settle before any clock edge
        #2 rst = 1'b1;
        #1;
        check_val("rst_csb", a_csb, 1'b1);
        check_val("rst_sck", a_sck, 1'b0);
        check_val("rst_mosi", a_mosi, 1'b0);
        check_val("rst_busy", a_busy, 1'b0);
        check_val("rst_done", a_done, 1'b0);
        check_val("rst_b_csb", b_csb, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_val("ready_after_rst", a_ready, 1'b1);

        // Idle: 100 cycles with no request
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (a_csb !== 1'b1 || a_sck !== 1'b0 || a_mosi !== 1'b0 || a_busy !== 1'b0) bad++;
            if (b_csb !== 1'b1 || b_sck !== 1'b0 || b_mosi !== 1'b0 || b_busy !== 1'b0) bad++;
        end
        check_val("idle_quiet", bad, 0);

        // Single 0xA5 frame
        d0 = a_done_cnt; nf = a_fw.size();
        send_a(8'hA5, t0, bsy, rdy);
        check_val("a5_busy_t1", bsy, 1'b1);
        check_val("a5_ready_t1", rdy, 1'b0);
        wait_ready_a(rc);
        check_val("a5_ready_at", rc - t0, 38);
        check_val("a5_frames", a_fw.size() - nf, 1);
        check_val("a5_word", a_fw[a_fw.size()-1], 32'hA5);
        check_val("a5_rises", a_fr[a_fr.size()-1], 8);
        check_val("a5_csb_len", a_fl[a_fl.size()-1], 34);
        check_val("a5_csb_fall", a_fall_cyc - t0, 1);
        check_val("a5_done_cnt", a_done_cnt - d0, 1);
        check_val("a5_done_at_csb_rise", a_done_cyc, a_rise_cyc);

        // Back-to-back with valid held high
        na = a_acc.size(); nf = a_fw.size();
        @(posedge clk); #1;
        a_data = 8'h01; a_valid = 1'b1;
        for (int i = 0; i < 100 && a_acc.size() <= na; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        a_data = 8'hFF;
        for (int i = 0; i < 200 && a_acc.size() <= na + 1; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        check_val("b2b_accepts", a_acc.size() - na, 2);
        if (a_acc.size() >= na + 2) begin
            t0 = a_acc[na]; t1 = a_acc[na+1];
            $display("xfer a b2b t0=%0d t1=%0d", t0, t1);
            check_val("b2b_spacing", t1 - t0, 38);
        end
        wait_ready_a(rc);
        check_val("b2b_frames", a_fw.size() - nf, 2);
        if (a_fw.size() >= nf + 2) begin
            check_val("b2b_word0", a_fw[nf], 32'h01);
            check_val("b2b_word1", a_fw[nf+1], 32'hFF);
            check_val("b2b_rises1", a_fr[nf+1], 8);
        end

        // Request while busy must be ignored
        na = a_acc.size(); nf = a_fw.size();
        send_a(8'h3C, t0, bsy, rdy);
        repeat (3) @(posedge clk);
        #1 a_data = 8'hC3; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        wait_ready_a(rc);
        repeat (10) @(negedge clk);
        #1;
        check_val("ign_accepts", a_acc.size() - na, 1);
        check_val("ign_frames", a_fw.size() - nf, 1);
        check_val("ign_word", a_fw[a_fw.size()-1], 32'h3C);

        // Reset at the 5th SCK rise
        send_a(8'h5A, t0, bsy, rdy);
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!a_csb && a_rises == 5) begin bad = 0; break; end
        end
        check_val("mid_rst_reach5", bad, 0);
        d0 = a_done_cnt;
        rst = 1'b1;
        #1;
        check_val("mid_rst_csb", a_csb, 1'b1);
        check_val("mid_rst_sck", a_sck, 1'b0);
        check_val("mid_rst_done", a_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_ready", a_ready, 1'b1);
        check_val("mid_rst_no_done", a_done_cnt - d0, 0);
        nf = a_fw.size();
        send_a(8'h96, t0, bsy, rdy);
        wait_ready_a(rc);
        check_val("post_rst_frames", a_fw.size() - nf, 1);
        check_val("post_rst_word", a_fw[a_fw.size()-1], 32'h96);
        check_val("post_rst_done", a_done_cnt - d0, 1);

        // 32-bit frame with CLK_DIV=1
        nf = b_fw.size(); d0 = b_done_cnt;
        send_b(32'hDEADBEEF, t0);
        wait_ready_b(rc);
        check_val("b_ready_at", rc - t0, 68);
        check_val("b_frames", b_fw.size() - nf, 1);
        check_val("b_word", b_fw[b_fw.size()-1], 32'hDEADBEEF);
        check_val("b_rises", b_fr[b_fr.size()-1], 32);
        check_val("b_csb_len", b_fl[b_fl.size()-1], 65);
        check_val("b_sck_period", b_per_bad, 0);
        check_val("b_done_cnt", b_done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
